// File: rtl/scan_pkg.sv
// scan_pkg
//   Shared definitions for the digit scan sequencer: FSM state encoding
//   and default slot timing.
package scan_pkg;

   // FSM state encoding; also presented on the sequencer's o_state output.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // Default timing: cycles of blanking and of drive in every slot.
   localparam int BLANK_CYC_DEF = 2;
   localparam int DRIVE_CYC_DEF = 4;
   // Default interval counter width; must hold max(BLANK_CYC, DRIVE_CYC).
   localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/next_unmasked_idx.sv
// next_unmasked_idx
//   Circular priority search over a 4-bit slot mask. Starting just above
//   i_cur and wrapping past 3 to 0, it returns the first enabled index.
//   If i_cur is the only enabled index (or the mask is empty) the result
//   is i_cur itself.
// Ports:
//   i_mask [3:0]  bit i = 1 enables slot index i
//   i_cur  [1:0]  index the search starts after
//   o_next [1:0]  next enabled index
//   o_wrap        1 when o_next <= i_cur (search wrapped or stayed put)
import scan_pkg::*;

module next_unmasked_idx (
   input  logic [3:0] i_mask,
   input  logic [1:0] i_cur,
   output logic [1:0] o_next,
   output logic       o_wrap
);

   logic [1:0] w_cand;
   logic       w_found;

   always_comb begin
      o_next  = i_cur;
      w_found = 1'b0;
      w_cand  = i_cur;
      // Offsets 1..4; offset 4 lands back on i_cur (single-slot mask).
      for (int k = 1; k <= 4; k++) begin
         w_cand = i_cur + 2'(k);
         if (!w_found && i_mask[w_cand]) begin
            o_next  = w_cand;
            w_found = 1'b1;
         end
      end
      o_wrap = (o_next <= i_cur);
   end

endmodule

// File: rtl/digit_scan_seq.sv
// digit_scan_seq
//   Drives the W/En inputs of a 2-to-4 enable decoder so its one-hot outputs
//   time-multiplex four shared-bus loads. Each enabled slot gets BLANK_CYC
//   cycles with En=0 followed by DRIVE_CYC cycles with En=1; masked slots
//   are skipped. Completion of each slot and of each frame is pulsed.
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset (overrides i_run)
//   i_run          1 = scan; 0 = abort to idle
//   i_mask [3:0]   slot enables, sampled only in IDLE and at slot boundaries
//   o_w    [1:0]   current slot index (decoder W)
//   o_en           decoder enable
//   o_slot_done    one-cycle pulse after a slot's drive interval completes
//   o_frame_done   one-cycle pulse when that slot was the last before wrap
//   o_state [1:0]  current FSM state (scan_state_t encoding)
// Handshake: none; i_run is a level, outputs are registered levels/pulses.
import scan_pkg::*;

module digit_scan_seq #(
   parameter int BLANK_CYC = BLANK_CYC_DEF,
   parameter int DRIVE_CYC = DRIVE_CYC_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_run,
   input  logic [3:0] i_mask,
   output logic [1:0] o_w,
   output logic       o_en,
   output logic       o_slot_done,
   output logic       o_frame_done,
   output logic [1:0] o_state
);

   // Terminal counts; BLANK_LAST is unused when BLANK_CYC = 0.
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
   localparam bit               NO_BLANK   = (BLANK_CYC == 0);

   scan_state_t      r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [1:0]       r_w, w_w_nx;
   logic             r_en, w_en_nx;
   logic             r_slot_done, w_slot_done_nx;
   logic             r_frame_done, w_frame_done_nx;

   logic [1:0]       w_next_idx, w_first_idx;
   logic             w_wrap, w_first_wrap_unused;

   // Boundary search: next enabled index after the slot just driven.
   next_unmasked_idx u_next (
      .i_mask (i_mask),
      .i_cur  (r_w),
      .o_next (w_next_idx),
      .o_wrap (w_wrap)
   );

   // Starting after index 3 yields the lowest enabled index.
   next_unmasked_idx u_first (
      .i_mask (i_mask),
      .i_cur  (2'd3),
      .o_next (w_first_idx),
      .o_wrap (w_first_wrap_unused)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_w          <= 2'd0;
         r_en         <= 1'b0;
         r_slot_done  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_w          <= w_w_nx;
         r_en         <= w_en_nx;
         r_slot_done  <= w_slot_done_nx;
         r_frame_done <= w_frame_done_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_cnt_nx        = r_cnt + CNT_W'(1);
      w_w_nx          = r_w;
      w_en_nx         = r_en;
      w_slot_done_nx  = 1'b0;
      w_frame_done_nx = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            w_w_nx   = 2'd0;
            w_en_nx  = 1'b0;
            if (i_run && (i_mask != 4'd0)) begin
               w_w_nx = w_first_idx;
               if (NO_BLANK) begin
                  w_state_nx = ST_DRIVE;
                  w_en_nx    = 1'b1;
               end else begin
                  w_state_nx = ST_BLANK;
               end
            end
         end

         ST_BLANK: begin
            if (!i_run) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
               w_w_nx     = 2'd0;
               w_en_nx    = 1'b0;
            end else if (r_cnt == BLANK_LAST) begin
               w_state_nx = ST_DRIVE;
               w_cnt_nx   = '0;
               w_en_nx    = 1'b1;
            end
         end

         ST_DRIVE: begin
            if (!i_run) begin
               // Aborted slot: no completion pulses.
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
               w_w_nx     = 2'd0;
               w_en_nx    = 1'b0;
            end else if (r_cnt == DRIVE_LAST) begin
               w_slot_done_nx  = 1'b1;
               w_frame_done_nx = w_wrap;
               w_cnt_nx        = '0;
               if (i_mask == 4'd0) begin
                  // Completed slot still reports; scan then parks.
                  w_state_nx = ST_IDLE;
                  w_w_nx     = 2'd0;
                  w_en_nx    = 1'b0;
               end else begin
                  w_w_nx = w_next_idx;
                  if (NO_BLANK) begin
                     // En stays high while W steps to the next slot.
                     w_state_nx = ST_DRIVE;
                     w_en_nx    = 1'b1;
                  end else begin
                     w_state_nx = ST_BLANK;
                     w_en_nx    = 1'b0;
                  end
               end
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_w_nx     = 2'd0;
            w_en_nx    = 1'b0;
         end
      endcase
   end

   assign o_w          = r_w;
   assign o_en         = r_en;
   assign o_slot_done  = r_slot_done;
   assign o_frame_done = r_frame_done;
   assign o_state      = r_state;

endmodule

// File: tb/tb_digit_scan_seq.sv
// tb_digit_scan_seq
//   Randomized and directed stimulus for digit_scan_seq, checked every
//   cycle against a slot-timeline reference model.
module tb_digit_scan_seq;

   localparam int BLANK = 2;
   localparam int DRIVE = 4;
   localparam int PER   = BLANK + DRIVE;

   logic       clk;
   logic       rst;
   logic       run;
   logic [3:0] mask;
   logic [1:0] o_w;
   logic       o_en;
   logic       o_slot_done;
   logic       o_frame_done;
   logic [1:0] o_state;

   digit_scan_seq #(
      .BLANK_CYC (BLANK),
      .DRIVE_CYC (DRIVE),
      .CNT_W     (8)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_run        (run),
      .i_mask       (mask),
      .o_w          (o_w),
      .o_en         (o_en),
      .o_slot_done  (o_slot_done),
      .o_frame_done (o_frame_done),
      .o_state      (o_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // Packed expected output: {state[1:0], w[1:0], en, slot_done, frame_done}
   logic [6:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A scan is a sequence of slots each PER cycles long; m_t is the
   // position inside the current slot, En is high in the tail DRIVE cycles.
   bit m_active;
   int m_cur;
   int m_t;
   bit m_sd, m_fd;

   function automatic int next_enabled(input int cur, input logic [3:0] m);
      for (int k = 1; k <= 4; k++) begin
         if (m[(cur + k) % 4]) return (cur + k) % 4;
      end
      return cur;
   endfunction

   task automatic model_edge();
      int nx;
      m_sd = 1'b0;
      m_fd = 1'b0;
      if (rst) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (run && mask != 4'd0) begin
            m_active = 1'b1;
            m_cur    = next_enabled(3, mask);
            m_t      = 0;
         end
      end else if (!run) begin
         m_active = 1'b0;
      end else begin
         m_t++;
         if (m_t == PER) begin
            nx   = next_enabled(m_cur, mask);
            m_sd = 1'b1;
            m_fd = (nx <= m_cur);
            if (mask == 4'd0) m_active = 1'b0;
            else begin
               m_cur = nx;
               m_t   = 0;
            end
         end
      end
   endtask

   function automatic logic [6:0] model_out();
      logic [1:0] st;
      logic [1:0] w;
      logic       en;
      st = !m_active ? 2'd0 : (m_t < BLANK ? 2'd1 : 2'd2);
      w  = m_active ? 2'(m_cur) : 2'd0;
      en = m_active && (m_t >= BLANK);
      return {st, w, en, m_sd, m_fd};
   endfunction

   // ---------------- driver ----------------
   // One clock: model follows the edge, DUT outputs are compared mid-cycle.
   task automatic step();
      logic [6:0] e;
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_out());
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("state",      {6'd0, o_state},      {6'd0, e[6:5]});
      check_eq("w",          {6'd0, o_w},          {6'd0, e[4:3]});
      check_eq("en",         {7'd0, o_en},         {7'd0, e[2]});
      check_eq("slot_done",  {7'd0, o_slot_done},  {7'd0, e[1]});
      check_eq("frame_done", {7'd0, o_frame_done}, {7'd0, e[0]});
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      m_active = 1'b0;
      m_cur    = 0;
      m_t      = 0;
      m_sd     = 1'b0;
      m_fd     = 1'b0;
      rst  = 1'b1;
      run  = 1'b0;
      mask = 4'b0000;
      @(negedge clk);
      run_cycles(3);
      rst = 1'b0;
      run_cycles(2);

      // Full mask: W 0,1,2,3,0 with frame pulse after slot 3.
      mask = 4'b1111;
      run  = 1'b1;
      run_cycles(5 * PER + 2);

      // Alternating slots 1 and 3.
      run = 1'b0;
      run_cycles(2);
      mask = 4'b1010;
      run  = 1'b1;
      run_cycles(4 * PER + 1);

      // Single slot: every slot completion is also a frame completion.
      run = 1'b0;
      run_cycles(1);
      mask = 4'b0100;
      run  = 1'b1;
      run_cycles(3 * PER + 1);

      // Empty mask keeps the scan idle; then one slot enabled.
      run = 1'b0;
      run_cycles(1);
      mask = 4'b0000;
      run  = 1'b1;
      run_cycles(8);
      mask = 4'b0001;
      run_cycles(PER + 2);

      // Mask cleared mid-slot: completed slot still reports, then idle.
      mask = 4'b0000;
      run_cycles(2 * PER);

      // Abort on the second drive cycle of slot 1, then restart.
      mask  = 4'b1111;
      guard = 0;
      while (!(m_active && m_cur == 1 && m_t == BLANK + 1) && guard < 4 * PER) begin
         step();
         guard++;
      end
      check_eq("abort_reach", {7'd0, (guard < 4 * PER)}, 8'd1);
      run = 1'b0;
      run_cycles(3);
      mask = 4'b0110;
      run  = 1'b1;
      run_cycles(2 * PER);

      // Reset mid-drive with run held high.
      mask  = 4'b1111;
      guard = 0;
      while (!(m_active && m_t == BLANK + 2) && guard < 4 * PER) begin
         step();
         guard++;
      end
      check_eq("reset_reach", {7'd0, (guard < 4 * PER)}, 8'd1);
      rst = 1'b1;
      run_cycles(2);
      rst = 1'b0;
      run_cycles(2 * PER);

      // Random traffic: mask changes, aborts and resets at random points.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) run = ~run;
         else if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      run_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus loop were ever to stall.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

endmodule
